seven_seg_mux_driver: RTL and testbench

- Time-multiplexed driver for an N-digit common-anode/cathode seven-segment display.
- Each digit shows one hex nibble of a loaded value, with optional leading-zero suppression, per-digit blanking and decimal points.
- Sits between datapath result registers (e.g. multiplier product) and board pins.
- New values are double-buffered and applied only at a frame boundary, so the display never tears.

---
 rtl/seven_seg_mux_driver_pkg.sv | 29 ++
 rtl/seven_seg_mux_driver_hex_decode.sv | 9 +
 rtl/seven_seg_mux_driver.sv | 114 +++++++++++
 tb/tb_seven_seg_mux_driver.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_mux_driver_pkg.sv
// seven_seg_mux_driver_pkg: segment patterns and bit positions shared by the seven-segment driver.
package seven_seg_mux_driver_pkg;
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b0011111;
    localparam logic [6:0] SEG_C     = 7'b1001110;
    localparam logic [6:0] SEG_D     = 7'b0111101;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_F     = 7'b1000111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam int SEG_BIT_A = 6;
    localparam int SEG_BIT_B = 5;
    localparam int SEG_BIT_C = 4;
    localparam int SEG_BIT_D = 3;
    localparam int SEG_BIT_E = 2;
    localparam int SEG_BIT_F = 1;
    localparam int SEG_BIT_G = 0;
    localparam logic [6:0] SEG_LUT [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                           SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
endpackage

// File: rtl/seven_seg_mux_driver_hex_decode.sv
// seven_seg_hex_decode: combinational hex nibble to {a..g} segment pattern.
module seven_seg_hex_decode
    import seven_seg_mux_driver_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    always_comb seg = SEG_LUT[nib];
endmodule

// File: rtl/seven_seg_mux_driver.sv
// seven_seg_mux_driver: time-multiplexed N-digit hex display driver with tear-free double buffering.
module seven_seg_mux_driver
    import seven_seg_mux_driver_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    lz_en,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);
    localparam int W  = 4 * NUM_DIGITS;
    localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] IDX_LAST = DW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE = NUM_DIGITS'(1);
    localparam logic SEG_INV = SEG_ACTIVE_LOW != 0;
    localparam logic AN_INV  = AN_ACTIVE_LOW != 0;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DW-1:0]         idx_q, idx_d;
    logic [W-1:0]          sh_value_q, sh_value_d, fr_value_q, fr_value_d;
    logic [NUM_DIGITS-1:0] sh_blank_q, sh_blank_d, fr_blank_q, fr_blank_d;
    logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d, fr_dp_q, fr_dp_d;
    logic                  sh_lz_q, sh_lz_d, fr_lz_q, fr_lz_d;
    logic                  pending_q, pending_d;
    logic [6:0]            seg_q, seg_d, hex_seg;
    logic                  dp_q, dp_d, tick_q, tick_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  cnt_wrap, boundary, take_live, take_sh, blank, dp_bit, lz_off;
    logic [3:0]            nib;

    seven_seg_hex_decode u_dec (.nib(nib), .seg(hex_seg));

    always_comb begin
        cnt_wrap   = cnt_q == CNT_LAST;
        boundary   = cnt_wrap && idx_q == IDX_LAST;
        cnt_d      = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d      = !cnt_wrap ? idx_q : (idx_q == IDX_LAST ? '0 : idx_q + 1'b1);
        sh_value_d = load ? value : sh_value_q;
        sh_blank_d = load ? blank_mask : sh_blank_q;
        sh_dp_d    = load ? dp_mask : sh_dp_q;
        sh_lz_d    = load ? lz_en : sh_lz_q;
        pending_d  = !boundary && (load || pending_q);
        // A load landing on the boundary itself skips the shadow so it is not a frame late
        take_live  = boundary && load;
        take_sh    = boundary && !load && pending_q;
        fr_value_d = take_live ? value : (take_sh ? sh_value_q : fr_value_q);
        fr_blank_d = take_live ? blank_mask : (take_sh ? sh_blank_q : fr_blank_q);
        fr_dp_d    = take_live ? dp_mask : (take_sh ? sh_dp_q : fr_dp_q);
        fr_lz_d    = take_live ? lz_en : (take_sh ? sh_lz_q : fr_lz_q);
        nib        = 4'(fr_value_q >> {idx_q, 2'b00});
        blank      = 1'(fr_blank_q >> idx_q);
        dp_bit     = 1'(fr_dp_q >> idx_q);
        // Suppressed when this nibble and every one above it are zero
        lz_off     = fr_lz_q && idx_q != '0 && (fr_value_q >> {idx_q, 2'b00}) == '0;
        seg_d      = ((blank || lz_off) ? SEG_BLANK : hex_seg) ^ {7{SEG_INV}};
        dp_d       = (!blank && dp_bit) ^ SEG_INV;
        an_d       = (AN_ONE << idx_q) ^ {NUM_DIGITS{AN_INV}};
        tick_d     = boundary;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            sh_value_q <= '0;
            sh_blank_q <= '0;
            sh_dp_q    <= '0;
            sh_lz_q    <= 1'b0;
            pending_q  <= 1'b0;
            fr_value_q <= '0;
            fr_blank_q <= '0;
            fr_dp_q    <= '0;
            fr_lz_q    <= 1'b0;
            seg_q      <= {7{SEG_INV}};
            dp_q       <= SEG_INV;
            an_q       <= {NUM_DIGITS{AN_INV}};
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sh_value_q <= sh_value_d;
            sh_blank_q <= sh_blank_d;
            sh_dp_q    <= sh_dp_d;
            sh_lz_q    <= sh_lz_d;
            pending_q  <= pending_d;
            fr_value_q <= fr_value_d;
            fr_blank_q <= fr_blank_d;
            fr_dp_q    <= fr_dp_d;
            fr_lz_q    <= fr_lz_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            tick_q     <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = tick_q;
endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// tb_seven_seg_mux_driver: directed checks of refresh, double buffering, LZ, blanking and polarity.
module tb_seven_seg_mux_driver;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  dp_mask = '0;
    logic        lz_en = 1'b0;
    logic        load = 1'b0;
    logic [6:0]  seg, seg_l;
    logic        dp, dp_l, ft, ft_l;
    logic [3:0]  an, an_l;
    int          tests = 0;
    int          fails = 0;
    logic [6:0]  cap_seg [4];
    logic [3:0]  cap_an [4];
    logic        cap_dp [4];
    logic        cap_stable, cap_ft_ok;

    always #5 clk = ~clk;

    seven_seg_mux_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut (
        .clk(clk), .reset(reset), .value(value), .blank_mask(blank_mask), .dp_mask(dp_mask),
        .lz_en(lz_en), .load(load), .seg(seg), .dp(dp), .an(an), .frame_tick(ft));

    seven_seg_mux_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_low (
        .clk(clk), .reset(reset), .value(value), .blank_mask(blank_mask), .dp_mask(dp_mask),
        .lz_en(lz_en), .load(load), .seg(seg_l), .dp(dp_l), .an(an_l), .frame_tick(ft_l));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] bm, input logic [3:0] dm, input logic lz);
        value = v; blank_mask = bm; dp_mask = dm; lz_en = lz; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic wait_tick;
        int n = 0;
        do begin
            step();
            n++;
        end while (!ft && n < 40);
        if (!ft) begin
            tests++; fails++;
            $display("FAIL wait_tick: frame_tick not seen within %0d cycles", n);
        end
    endtask

    // Records one frame starting just after a frame_tick sample; the last step lands on the next tick
    task automatic capture_frame;
        cap_stable = 1'b1;
        cap_ft_ok = 1'b1;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++) begin
                step();
                if (j == 0) begin
                    cap_seg[k] = seg; cap_an[k] = an; cap_dp[k] = dp;
                end else if (seg !== cap_seg[k] || an !== cap_an[k] || dp !== cap_dp[k])
                    cap_stable = 1'b0;
                if (ft !== (k * 4 + j == 15)) cap_ft_ok = 1'b0;
            end
    endtask

    task automatic check_frame(input string name, input logic [6:0] es [4], input logic ed [4]);
        logic [3:0] ea [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        tests++;
        if (cap_stable !== 1'b1 || cap_ft_ok !== 1'b1) begin
            fails++;
            $display("FAIL %s timing: stable=%b tick_ok=%b, both required 1", name, cap_stable, cap_ft_ok);
        end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (cap_an[k] !== ea[k] || cap_seg[k] !== es[k] || cap_dp[k] !== ed[k]) begin
                fails++;
                $display("FAIL %s digit%0d: an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
                         name, k, cap_an[k], cap_seg[k], cap_dp[k], ea[k], es[k], ed[k]);
            end
        end
    endtask

    task automatic test_reset;
        int n;
        reset = 1'b1;
        repeat (3) step();
        tests++;
        if (an !== 4'b0000 || seg !== 7'b0000000 || dp !== 1'b0 || ft !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: an=%b seg=%b dp=%b ft=%b, required 0000 0000000 0 0", an, seg, dp, ft);
        end
        tests++;
        if (an_l !== 4'b1111 || seg_l !== 7'b1111111 || dp_l !== 1'b1 || ft_l !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold_low: an=%b seg=%b dp=%b ft=%b, required 1111 1111111 1 0", an_l, seg_l, dp_l, ft_l);
        end
        reset = 1'b0;
        step();
        tests++;
        if (an !== 4'b0001 || seg !== 7'b1111110 || dp !== 1'b0 || ft !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: an=%b seg=%b dp=%b ft=%b, required 0001 1111110 0 0", an, seg, dp, ft);
        end
        tests++;
        if (an_l !== 4'b1110 || seg_l !== 7'b0000001 || dp_l !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_low: an=%b seg=%b dp=%b, required 1110 0000001 1", an_l, seg_l, dp_l);
        end
        n = 1;
        while (!ft && n < 40) begin
            step();
            n++;
        end
        tests++;
        if (n != 16 || !ft) begin
            fails++;
            $display("FAIL first_tick: seen after %0d cycles (ft=%b), required 16", n, ft);
        end
    endtask

    task automatic test_digits;
        do_load(16'h12AF, 4'b0000, 4'b0000, 1'b0);
        wait_tick();
        capture_frame();
        check_frame("digits_12AF", '{7'b1000111, 7'b1110111, 7'b1101101, 7'b0110000}, '{0, 0, 0, 0});
    endtask

    task automatic test_tear_free;
        repeat (5) step();
        tests++;
        if (an !== 4'b0010 || seg !== 7'b1110111) begin
            fails++;
            $display("FAIL tear_pre: an=%b seg=%b, required 0010 1110111", an, seg);
        end
        do_load(16'h3333, 4'b0000, 4'b0000, 1'b0);
        repeat (3) step();
        tests++;
        if (an !== 4'b0100 || seg !== 7'b1101101) begin
            fails++;
            $display("FAIL tear_digit2: an=%b seg=%b, required 0100 1101101", an, seg);
        end
        repeat (4) step();
        tests++;
        if (an !== 4'b1000 || seg !== 7'b0110000) begin
            fails++;
            $display("FAIL tear_digit3: an=%b seg=%b, required 1000 0110000", an, seg);
        end
        repeat (3) step();
        tests++;
        if (ft !== 1'b1) begin
            fails++;
            $display("FAIL tear_tick: frame_tick=%b, required 1", ft);
        end
        capture_frame();
        check_frame("tear_3333", '{7'b1111001, 7'b1111001, 7'b1111001, 7'b1111001}, '{0, 0, 0, 0});
    endtask

    task automatic test_boundary_load;
        repeat (15) step();
        value = 16'hC0DE; blank_mask = '0; dp_mask = '0; lz_en = 1'b0; load = 1'b1;
        step();
        load = 1'b0;
        tests++;
        if (ft !== 1'b1) begin
            fails++;
            $display("FAIL boundary_tick: frame_tick=%b, required 1", ft);
        end
        capture_frame();
        check_frame("boundary_C0DE", '{7'b1001111, 7'b0111101, 7'b1111110, 7'b1001110}, '{0, 0, 0, 0});
    endtask

    task automatic test_lz;
        do_load(16'h0050, 4'b0000, 4'b1000, 1'b1);
        wait_tick();
        capture_frame();
        check_frame("lz_0050", '{7'b1111110, 7'b1011011, 7'b0000000, 7'b0000000}, '{0, 0, 0, 1});
        do_load(16'h0000, 4'b0000, 4'b0000, 1'b1);
        wait_tick();
        capture_frame();
        check_frame("lz_0000", '{7'b1111110, 7'b0000000, 7'b0000000, 7'b0000000}, '{0, 0, 0, 0});
    endtask

    task automatic test_blank;
        do_load(16'h1234, 4'b0100, 4'b0100, 1'b0);
        wait_tick();
        capture_frame();
        check_frame("blank_d2", '{7'b0110011, 7'b1111001, 7'b0000000, 7'b0110000}, '{0, 0, 0, 0});
    endtask

    task automatic test_reset_mid;
        repeat (5) step();
        do_load(16'hFFFF, 4'b0000, 4'b1111, 1'b0);
        repeat (2) step();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        step();
        tests++;
        if (an !== 4'b0001 || seg !== 7'b1111110 || dp !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_release: an=%b seg=%b dp=%b, required 0001 1111110 0", an, seg, dp);
        end
        wait_tick();
        capture_frame();
        check_frame("reset_mid_discard", '{7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110}, '{0, 0, 0, 0});
    endtask

    initial begin
        test_reset();
        test_digits();
        test_tear_free();
        test_boundary_load();
        test_lz();
        test_blank();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
